// File: rtl/dma_reg_pkg.sv
`default_nettype none
// ============================================================================
//  dma_reg_pkg
//  Shared definitions for the DMA address/count datapath: parameter defaults,
//  the special register offsets and the per-channel register record.
//  Revision: 1.0
// ============================================================================
package dma_reg_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DW     = 8;

  // Control offsets that live above the channel register pairs
  localparam logic [3:0] CLR_FF     = 4'hC;
  localparam logic [3:0] MASTER_CLR = 4'hD;

  // The four registers owned by one channel, at the default bus width
  typedef struct packed {
    logic [2*DEF_DW-1:0] base_addr;
    logic [2*DEF_DW-1:0] base_cnt;
    logic [2*DEF_DW-1:0] cur_addr;
    logic [2*DEF_DW-1:0] cur_cnt;
  } ch_regs_t;

endpackage
`default_nettype wire

// File: rtl/dma_ch_counter.sv
`default_nettype none
// ============================================================================
//  dma_ch_counter
//  One DMA channel: base/current address and count registers, byte-wide
//  programming, and the step / terminal-count / auto-reload behaviour.
//
//  Ports
//    clk, rst_n      block clock, asynchronous active-low reset
//    clr             master clear of all four registers
//    wr_en           byte write into base and current of the selected pair
//    wr_cnt          0 = address pair, 1 = count pair
//    wr_hi           0 = low byte, 1 = high byte
//    wr_data         byte to write
//    step            one transfer completed on this channel
//    dec             address direction for this step (1 = down)
//    autoinit        reload current from base on terminal count
//    cur_addr        current address
//    cur_cnt         current count
//    tc_hit          this step hits terminal count (combinational)
//    adstb_hit       this step changes the upper address byte (combinational)
//  Revision: 1.0
// ============================================================================
module dma_ch_counter
  import dma_reg_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wr_en,
  input  logic            wr_cnt,
  input  logic            wr_hi,
  input  logic [DW-1:0]   wr_data,
  input  logic            step,
  input  logic            dec,
  input  logic            autoinit,
  output logic [2*DW-1:0] cur_addr,
  output logic [2*DW-1:0] cur_cnt,
  output logic            tc_hit,
  output logic            adstb_hit
);

  localparam int AW = 2 * DW;

  logic [AW-1:0] base_addr;
  logic [AW-1:0] base_cnt;
  logic [AW-1:0] addr_step;
  logic [AW-1:0] next_addr;
  logic [AW-1:0] next_cnt;
  logic          cnt_zero;
  logic          reload;

  function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] r,
                                             input logic hi,
                                             input logic [DW-1:0] b);
    put_byte = hi ? {b, r[DW-1:0]} : {r[AW-1:DW], b};
  endfunction

  always_comb begin
    cnt_zero  = (cur_cnt == '0);
    reload    = cnt_zero && autoinit;
    addr_step = dec ? (cur_addr - AW'(1)) : (cur_addr + AW'(1));
    next_addr = reload ? base_addr : addr_step;
    next_cnt  = reload ? base_cnt  : (cur_cnt - AW'(1));
    tc_hit    = step && cnt_zero;
    // Any change of the high byte (step carry/borrow or a reload) forces
    // the external upper-address latch to be refreshed.
    adstb_hit = step && (next_addr[AW-1:DW] != cur_addr[AW-1:DW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr <= '0;
      base_cnt  <= '0;
      cur_addr  <= '0;
      cur_cnt   <= '0;
    end else if (clr) begin
      base_addr <= '0;
      base_cnt  <= '0;
      cur_addr  <= '0;
      cur_cnt   <= '0;
    end else if (wr_en) begin
      if (wr_cnt) begin
        base_cnt <= put_byte(base_cnt, wr_hi, wr_data);
        cur_cnt  <= put_byte(cur_cnt,  wr_hi, wr_data);
      end else begin
        base_addr <= put_byte(base_addr, wr_hi, wr_data);
        cur_addr  <= put_byte(cur_addr,  wr_hi, wr_data);
      end
    end else if (step) begin
      cur_addr <= next_addr;
      cur_cnt  <= next_cnt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_addr_datapath.sv
`default_nettype none
// ============================================================================
//  dma_addr_datapath
//  Multi-channel DMA address/count datapath with a byte-serial programming
//  port (program mode, HLDA=0) and address stepping (active mode, HLDA=1).
//
//  Ports
//    CLK, RESET_N    block clock, asynchronous active-low reset
//    CS_N, HLDA      chip select; hold acknowledge (0 program, 1 active)
//    IOR_N, IOW_N    register read / write strobes
//    ADDR_L          register select
//    DB_IN, DB_OUT   write data / read data, DB_OE enables the bus driver
//    CH_SEL          channel serviced in active mode
//    STEP, DEC       transfer-done pulse; address direction
//    AUTOINIT        reload from base on terminal count
//    ADDR_OUT        current address of CH_SEL (active mode only)
//    ADSTB, TC       upper-address strobe pulse; terminal-count pulse
//  Revision: 1.0
// ============================================================================
module dma_addr_datapath
  import dma_reg_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DW     = DEF_DW
) (
  input  logic                                      CLK,
  input  logic                                      RESET_N,
  input  logic                                      CS_N,
  input  logic                                      HLDA,
  input  logic                                      IOR_N,
  input  logic                                      IOW_N,
  input  logic [3:0]                                ADDR_L,
  input  logic [DW-1:0]                             DB_IN,
  output logic [DW-1:0]                             DB_OUT,
  output logic                                      DB_OE,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] CH_SEL,
  input  logic                                      STEP,
  input  logic                                      DEC,
  input  logic                                      AUTOINIT,
  output logic [2*DW-1:0]                           ADDR_OUT,
  output logic                                      ADSTB,
  output logic                                      TC
);

  localparam int         AW         = 2 * DW;
  localparam int         CSW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] PAIR_LIMIT = 4'(2 * NUM_CH);

  logic          prog;
  logic          pair_sel;
  logic          wr_done;
  logic          rd_done;
  logic          master_clr;
  logic          iow_q;
  logic          ior_q;
  logic          hlda_q;
  logic          byte_ptr;
  logic          tc_q;
  logic          adstb_q;
  logic [NUM_CH-1:0] tc_hit;
  logic [NUM_CH-1:0] adstb_hit;
  logic [AW-1:0] cur_addr [NUM_CH];
  logic [AW-1:0] cur_cnt  [NUM_CH];

  assign prog     = !CS_N && !HLDA;
  assign pair_sel = (ADDR_L < PAIR_LIMIT);

  // A strobe is only remembered as low while the port is actually selected,
  // so HLDA=1 or CS_N=1 traffic can never complete an access later on.
  assign wr_done    = prog && !iow_q && IOW_N;
  assign rd_done    = prog && !ior_q && IOR_N;
  assign master_clr = wr_done && (ADDR_L == MASTER_CLR);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      iow_q    <= 1'b1;
      ior_q    <= 1'b1;
      hlda_q   <= 1'b0;
      byte_ptr <= 1'b0;
      tc_q     <= 1'b0;
      adstb_q  <= 1'b0;
    end else begin
      iow_q  <= IOW_N || !prog;
      ior_q  <= IOR_N || !prog;
      hlda_q <= HLDA;
      if (wr_done) begin
        if (pair_sel) begin
          byte_ptr <= !byte_ptr;
        end else if ((ADDR_L == CLR_FF) || (ADDR_L == MASTER_CLR)) begin
          byte_ptr <= 1'b0;
        end
      end else if (rd_done && pair_sel) begin
        byte_ptr <= !byte_ptr;
      end
      tc_q    <= |tc_hit;
      adstb_q <= (HLDA && !hlda_q) || (|adstb_hit);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_ch_counter #(
      .DW(DW)
    ) u_ctr (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .clr      (master_clr),
      .wr_en    (wr_done && pair_sel && (ADDR_L[3:1] == 3'(g))),
      .wr_cnt   (ADDR_L[0]),
      .wr_hi    (byte_ptr),
      .wr_data  (DB_IN),
      // Out-of-range CH_SEL values match no channel, so the step is dropped
      .step     (HLDA && STEP && (CH_SEL == CSW'(g))),
      .dec      (DEC),
      .autoinit (AUTOINIT),
      .cur_addr (cur_addr[g]),
      .cur_cnt  (cur_cnt[g]),
      .tc_hit   (tc_hit[g]),
      .adstb_hit(adstb_hit[g])
    );
  end

  always_comb begin
    DB_OUT   = '0;
    ADDR_OUT = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pair_sel && (ADDR_L[3:1] == 3'(i))) begin
        if (ADDR_L[0]) begin
          DB_OUT = byte_ptr ? cur_cnt[i][AW-1:DW] : cur_cnt[i][DW-1:0];
        end else begin
          DB_OUT = byte_ptr ? cur_addr[i][AW-1:DW] : cur_addr[i][DW-1:0];
        end
      end
      if (HLDA && (CH_SEL == CSW'(i))) begin
        ADDR_OUT = cur_addr[i];
      end
    end
  end

  assign DB_OE = !CS_N && !HLDA && !IOR_N;
  assign TC    = tc_q;
  assign ADSTB = adstb_q;

endmodule
`default_nettype wire
